// File: rtl/sdram_rw_tester_if.sv
// Word-access handshake between a user-side requester and the SDRAM controller.
interface sdram_rw_tester_if;
   logic        WrEN_Sig;
   logic        RdEN_Sig;
   logic        Done_Sig;
   logic        Busy_Sig;
   logic [21:0] BRC_Addr;
   logic [15:0] WrData;
   logic [15:0] RdData;

   // requester side (this tester)
   modport master (
      output WrEN_Sig, RdEN_Sig, BRC_Addr, WrData,
      input  Done_Sig, Busy_Sig, RdData
   );

   // controller side
   modport slave (
      input  WrEN_Sig, RdEN_Sig, BRC_Addr, WrData,
      output Done_Sig, Busy_Sig, RdData
   );
endinterface

// File: rtl/sdram_rw_tester.sv
// SDRAM read/write tester: writes addr^SEED over [ADDR_FIRST..ADDR_LAST],
// reads the window back, counts mismatches and reports pass/fail/timeout.
module sdram_rw_tester #(
   parameter logic [21:0] ADDR_FIRST = 22'd0,
   parameter logic [21:0] ADDR_LAST  = 22'd255,
   parameter logic [15:0] SEED       = 16'hA5A5,
   parameter int          TIMEOUT    = 1023
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              Start_Sig,
   output logic              Test_Done_Sig,
   output logic              Pass_Sig,
   output logic              Timeout_Sig,
   output logic [15:0]       Err_Cnt,
   output logic [21:0]       Fail_Addr,
   sdram_rw_tester_if.master mem
);
   localparam logic [9:0] TMO = 10'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, FINISH} state_t;

   state_t      state, state_n;
   logic [21:0] addr, addr_n;
   logic [15:0] wdat, wdat_n;
   logic        wr_en, wr_en_n;
   logic        rd_en, rd_en_n;
   logic [15:0] err, err_n;
   logic [21:0] fail, fail_n;
   logic        first_fail, first_fail_n;
   logic [9:0]  tcnt, tcnt_n;
   logic        tmo, tmo_n;
   logic        pass, pass_n;
   logic        tdone, tdone_n;

   assign mem.WrEN_Sig  = wr_en;
   assign mem.RdEN_Sig  = rd_en;
   assign mem.BRC_Addr  = addr;
   assign mem.WrData    = wdat;
   assign Test_Done_Sig = tdone;
   assign Pass_Sig      = pass;
   assign Timeout_Sig   = tmo;
   assign Err_Cnt       = err;
   assign Fail_Addr     = fail;

   // State and every output register; reset clears them all at once.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state      <= IDLE;
         addr       <= '0;
         wdat       <= '0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         err        <= '0;
         fail       <= '0;
         first_fail <= 1'b0;
         tcnt       <= '0;
         tmo        <= 1'b0;
         pass       <= 1'b0;
         tdone      <= 1'b0;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         wdat       <= wdat_n;
         wr_en      <= wr_en_n;
         rd_en      <= rd_en_n;
         err        <= err_n;
         fail       <= fail_n;
         first_fail <= first_fail_n;
         tcnt       <= tcnt_n;
         tmo        <= tmo_n;
         pass       <= pass_n;
         tdone      <= tdone_n;
      end
   end

   // Next state and next register values; everything holds unless changed.
   always_comb begin
      state_n      = state;
      addr_n       = addr;
      wdat_n       = wdat;
      wr_en_n      = wr_en;
      rd_en_n      = rd_en;
      err_n        = err;
      fail_n       = fail;
      first_fail_n = first_fail;
      tcnt_n       = tcnt;
      tmo_n        = tmo;
      pass_n       = pass;
      tdone_n      = 1'b0;
      case (state)
         IDLE: begin
            if (Start_Sig) begin
               addr_n       = ADDR_FIRST;
               wdat_n       = ADDR_FIRST[15:0] ^ SEED;
               err_n        = '0;
               fail_n       = '0;
               first_fail_n = 1'b0;
               tcnt_n       = '0;
               tmo_n        = 1'b0;
               pass_n       = 1'b0;
               state_n      = WR;
            end
         end
         WR: begin
            tcnt_n = tcnt + 10'd1;
            // Done only counts once our own request is on the bus.
            if (wr_en && mem.Done_Sig) begin
               wr_en_n = 1'b0;
               state_n = WR_GAP;
            end else if (tcnt == TMO) begin
               wr_en_n = 1'b0;
               tmo_n   = 1'b1;
               state_n = FINISH;
            end else if (!wr_en && !mem.Busy_Sig) begin
               wr_en_n = 1'b1;
            end
         end
         WR_GAP: begin
            tcnt_n = '0;
            if (addr == ADDR_LAST) begin
               addr_n  = ADDR_FIRST;
               state_n = RD;
            end else begin
               addr_n  = addr + 22'd1;
               state_n = WR;
            end
            wdat_n = addr_n[15:0] ^ SEED;
         end
         RD: begin
            tcnt_n = tcnt + 10'd1;
            if (rd_en && mem.Done_Sig) begin
               rd_en_n = 1'b0;
               state_n = RD_GAP;
               if (mem.RdData != (addr[15:0] ^ SEED)) begin
                  if (err != 16'hFFFF) err_n = err + 16'd1;
                  if (!first_fail) begin
                     first_fail_n = 1'b1;
                     fail_n       = addr;
                  end
               end
            end else if (tcnt == TMO) begin
               rd_en_n = 1'b0;
               tmo_n   = 1'b1;
               state_n = FINISH;
            end else if (!rd_en && !mem.Busy_Sig) begin
               rd_en_n = 1'b1;
            end
         end
         RD_GAP: begin
            tcnt_n = '0;
            if (addr == ADDR_LAST) begin
               state_n = FINISH;
            end else begin
               addr_n  = addr + 22'd1;
               wdat_n  = addr_n[15:0] ^ SEED;
               state_n = RD;
            end
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Result is registered on entry to FINISH so it is valid with the done pulse.
      if (state_n == FINISH) begin
         tdone_n = 1'b1;
         pass_n  = (err_n == 16'd0) && !tmo_n;
      end
   end
endmodule
